// File: rtl/idct_pkg.sv
// ----------------------------------------------------------------------------
// idct_pkg : shared constants for the 8x8 inverse DCT (basis, widths, states)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package idct_pkg;

  localparam int CW_DEF     = 12;
  localparam int IW_DEF     = 16;
  localparam int PW_DEF     = 8;

  localparam int COEF_W     = 8;
  localparam int RND_SHIFT  = 7;
  localparam int RND_BIAS   = 64;
  // Eight products plus sign headroom on top of input + coefficient width.
  localparam int SUM_GROWTH = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef logic signed [COEF_W-1:0] coef_t;

  // C_MAT[k][n] = round(128 * a(k) * cos((2n+1) k pi / 16))
  localparam coef_t C_MAT [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

endpackage

`default_nettype wire

// File: rtl/idct_1d_core.sv
// ----------------------------------------------------------------------------
// idct_1d_core : combinational 8-point IDCT MAC with rounding and clamp
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module idct_1d_core
  import idct_pkg::*;
#(
  parameter int IN_W         = 12,
  parameter int OUT_W        = 16,
  parameter bit UNSIGNED_SAT = 1'b0
) (
  input  logic [8*IN_W-1:0]  data_i,
  output logic [8*OUT_W-1:0] data_o
);

  localparam int ACC_W = IN_W + COEF_W + SUM_GROWTH;

  localparam logic signed [ACC_W-1:0] SAT_HI = UNSIGNED_SAT ?
      ACC_W'((1 << OUT_W) - 1) : ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = UNSIGNED_SAT ?
      ACC_W'(0) : ACC_W'(-(1 << (OUT_W - 1)));

  logic signed [IN_W-1:0]  x_w   [8];
  logic signed [ACC_W-1:0] acc_w [8];
  logic signed [ACC_W-1:0] rnd_w [8];

  always_comb begin
    data_o = '0;
    for (int k = 0; k < 8; k++) begin
      x_w[k] = data_i[k*IN_W +: IN_W];
    end
    for (int n = 0; n < 8; n++) begin
      // Operands widened before multiplying so no product bits are lost.
      acc_w[n] = ACC_W'(RND_BIAS);
      for (int k = 0; k < 8; k++) begin
        acc_w[n] = acc_w[n] + ACC_W'(C_MAT[k][n]) * ACC_W'(x_w[k]);
      end
      rnd_w[n] = acc_w[n] >>> RND_SHIFT;
      if (rnd_w[n] > SAT_HI) begin
        data_o[n*OUT_W +: OUT_W] = SAT_HI[OUT_W-1:0];
      end else if (rnd_w[n] < SAT_LO) begin
        data_o[n*OUT_W +: OUT_W] = SAT_LO[OUT_W-1:0];
      end else begin
        data_o[n*OUT_W +: OUT_W] = rnd_w[n][OUT_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/full_idct.sv
// ----------------------------------------------------------------------------
// full_idct : streaming 8x8 2-D inverse DCT with ping-pong transpose buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_idct
  import idct_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int IW = IW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*CW-1:0] data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*PW-1:0] data_out,
  output logic [15:0]     blk_in,
  output logic [15:0]     blk_out
);

  logic [IW-1:0]   bank_q [2][8][8];
  logic [1:0]      full_q, full_d;
  logic            wp_q, rp_q;
  logic [2:0]      row_q, col_q;
  logic [0:0]      state_q, state_d;
  logic            out_valid_q, out_last_q;
  logic [8*PW-1:0] data_out_q;
  logic [15:0]     blk_in_q, blk_out_q;

  logic [8*IW-1:0] row_y_w, col_x_w;
  logic [8*PW-1:0] pix_w;
  logic            accept_w, blk_done_w, load_w, col_done_w;

  idct_1d_core #(
    .IN_W         (CW),
    .OUT_W        (IW),
    .UNSIGNED_SAT (1'b0)
  ) u_row (
    .data_i (data_in),
    .data_o (row_y_w)
  );

  idct_1d_core #(
    .IN_W         (IW),
    .OUT_W        (PW),
    .UNSIGNED_SAT (1'b1)
  ) u_col (
    .data_i (col_x_w),
    .data_o (pix_w)
  );

  assign in_ready   = ~full_q[wp_q];
  assign accept_w   = in_valid & ~full_q[wp_q];
  assign blk_done_w = accept_w & (row_q == 3'd7);
  // IDLE loads immediately when its bank is full, giving one-edge latency.
  assign load_w     = ((state_q == ST_STREAM) | full_q[rp_q]) & (~out_valid_q | out_ready);
  assign col_done_w = load_w & (col_q == 3'd7);

  always_comb begin
    col_x_w = '0;
    for (int k = 0; k < 8; k++) begin
      col_x_w[k*IW +: IW] = bank_q[rp_q][k][col_q];
    end
  end

  always_comb begin
    full_d  = full_q;
    state_d = state_q;
    if (blk_done_w) full_d[wp_q] = 1'b1;
    if (col_done_w) full_d[rp_q] = 1'b0;
    if (col_done_w) begin
      state_d = full_q[~rp_q] ? ST_STREAM : ST_IDLE;
    end else if (load_w) begin
      state_d = ST_STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_w) begin
      for (int n = 0; n < 8; n++) begin
        bank_q[wp_q][row_q][n] <= row_y_w[n*IW +: IW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q      <= 2'b00;
      state_q     <= ST_IDLE;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_out_q  <= '0;
      blk_in_q    <= 16'd0;
      blk_out_q   <= 16'd0;
    end else begin
      full_q  <= full_d;
      state_q <= state_d;
      if (accept_w) begin
        row_q <= row_q + 3'd1;
        if (blk_done_w) begin
          wp_q     <= ~wp_q;
          blk_in_q <= blk_in_q + 16'd1;
        end
      end
      if (load_w) begin
        data_out_q  <= pix_w;
        out_valid_q <= 1'b1;
        out_last_q  <= (col_q == 3'd7);
        col_q       <= col_q + 3'd1;
        if (col_done_w) rp_q <= ~rp_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q & out_ready & out_last_q) begin
        blk_out_q <= blk_out_q + 16'd1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign blk_in    = blk_in_q;
  assign blk_out   = blk_out_q;

endmodule

`default_nettype wire
